// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and the hard-wired zero register.
package cpu_pkg;

  localparam int CPU_AW   = 5;
  localparam int CPU_DW   = 32;
  localparam int REG_ZERO = 0;

  // Increment modulo n, used for the round-robin pointer.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr wins.
module wb_rr_pick #(
  parameter  int NREQ = 3,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [GW-1:0]   o_idx,
  output logic            o_any
);

  logic          w_found;
  logic [GW-1:0] w_idx;

  // Two passes: indices >= ptr first, then wrap to the lowest set index.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i] && (GW'(i) >= i_ptr)) begin
        w_found = 1'b1;
        w_idx   = GW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i]) begin
        w_found = 1'b1;
        w_idx   = GW'(i);
      end
    end
  end

  assign o_idx   = w_idx;
  assign o_any   = w_found;
  assign o_grant = w_found ? (NREQ'(1) << w_idx) : '0;

endmodule

// File: rtl/wb_port_arb.sv
// Write-back port arbiter: one registered register-file write per cycle.
// WB_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
module wb_port_arb
  import cpu_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int AW   = CPU_AW,
  parameter  int DW   = CPU_DW,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic               rf_wen,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic [GW-1:0]      wb_id
);

  logic [NREQ-1:0] w_req_gated;
  logic [NREQ-1:0] w_grant;
  logic [GW-1:0]   w_idx;
  logic [GW-1:0]   w_pick_ptr;
  logic            w_xfer;
  logic [AW-1:0]   w_addr_terms [NREQ];
  logic [DW-1:0]   w_data_terms [NREQ];
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  logic            r_wen;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [GW-1:0]   r_id;

  // Reset and hold suppress every grant, so nothing is consumed.
  assign w_req_gated = req_valid & {NREQ{rst_n & ~hold}};

`ifdef WB_ARB_RR_EN
  logic [GW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= GW'(wrap_inc(int'(w_idx), NREQ));
    end
  end

  assign w_pick_ptr = r_ptr;
`else
  assign w_pick_ptr = '0;
`endif

  wb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req   (w_req_gated),
    .i_ptr   (w_pick_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_xfer)
  );

  assign req_ready = w_grant;

  // One-hot AND-OR mux of the winning requester's address and data.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
    assign w_addr_terms[gi] = req_addr[gi*AW +: AW] & {AW{w_grant[gi]}};
    assign w_data_terms[gi] = req_data[gi*DW +: DW] & {DW{w_grant[gi]}};
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_addr = w_sel_addr | w_addr_terms[i];
      w_sel_data = w_sel_data | w_data_terms[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_id    <= '0;
    end else if (w_xfer) begin
      // x0 writes are consumed but never enabled into the register file.
      r_wen   <= (w_sel_addr != AW'(REG_ZERO));
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
      r_id    <= w_idx;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign wb_id    = r_id;

endmodule

// File: tb/tb_wb_port_arb.sv
// Randomized scoreboard bench for wb_port_arb; arbitration mode follows WB_ARB_RR_EN.
module tb_wb_port_arb;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int GW   = $clog2(NREQ);
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [GW-1:0] id;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_wen;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [GW-1:0]      wb_id;

  always #5 clk = ~clk;

  wb_port_arb #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_id     (wb_id)
  );

  // Requester-side state and reference model
  bit            st_v [NREQ];
  logic [AW-1:0] st_a [NREQ];
  logic [DW-1:0] st_d [NREQ];
  int            m_ptr;
  exp_t          m_last;
  exp_t          q [$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    st_v[i] = 1'b1;
    st_a[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, (1 << AW) - 1));
    st_d[i] = $urandom;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_v[i] = 1'b1;
    st_a[i] = a;
    st_d[i] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) st_v[i] = 1'b0;
  endtask

  // One cycle: mutate requests, drive, check grant, push expected write-back.
  task automatic step(input bit h, input bit rn, input int pnew, input int pdrop);
    int g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (st_v[i]) begin
        if (int'($urandom_range(0, 99)) < pdrop) st_v[i] = 1'b0;
      end else if (int'($urandom_range(0, 99)) < pnew) begin
        new_req(i);
      end
    end
    hold  = h;
    rst_n = rn;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = st_v[i];
      req_addr[i*AW +: AW]   = st_a[i];
      req_data[i*DW +: DW]   = st_d[i];
    end
    #1;
    g = -1;
    if (rn && !h) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && st_v[i]) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (!rn) begin
      m_last = '{1'b0, '0, '0, '0};
      m_ptr  = 0;
    end else if (g >= 0) begin
      m_last.wen  = (st_a[g] != 0);
      m_last.addr = st_a[g];
      m_last.data = st_d[g];
      m_last.id   = GW'(g);
      if (RR) m_ptr = (g + 1) % NREQ;
      st_v[g] = 1'b0;
    end else begin
      m_last.wen = 1'b0;
    end
    q.push_back(m_last);
  endtask

  // Monitor: every registered write-back is compared with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rf_wen", 64'(rf_wen), 64'(e.wen));
        chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
        chk("wb_id", 64'(wb_id), 64'(e.id));
        if (e.wen) $display("wb id=%0d addr=%0d data=0x%08h", e.id, e.addr, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    m_ptr     = 0;
    m_last    = '{1'b0, '0, '0, '0};
    clear_reqs();

    // Reset with every requester valid, then release
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), $urandom);
    repeat (3) step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 100, 0);

    // Continuous requests on all ports
    repeat (6) step(1'b0, 1'b1, 100, 0);

    // Write to x0 from requester 1 only, then all ports again
    clear_reqs();
    set_req(1, '0, 32'hDEADBEEF);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, 100, 0);

    // Hold with pending requests
    repeat (3) step(1'b1, 1'b1, 100, 0);
    repeat (3) step(1'b0, 1'b1, 100, 0);

    // Reset right after a grant of register 5
    clear_reqs();
    set_req(0, AW'(5), 32'h0000_0555);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 100, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 100, 0);

    // Randomized traffic with occasional hold and reset
    repeat (300) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) != 0), 50, 10);
    end

    clear_reqs();
    repeat (3) step(1'b0, 1'b1, 0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
